// File: rtl/spinner_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spinner_arb_pkg
// Description : Shared constants, encoder direction type and quadrature
//               next-state function for the spinner arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package spinner_arb_pkg;

  localparam int SRC_N   = 4;
  localparam int POS_W   = 12;
  localparam int POS_MAX = 2047;

  typedef enum logic {
    FWD = 1'b0,
    REV = 1'b1
  } enc_dir_t;

  // One Gray step of the {A,B} pair.
  // FWD walks 11->01->00->10->11, REV walks the same ring backwards.
  function automatic logic [1:0] next_gray(input logic [1:0] ab, input enc_dir_t dir);
    logic [1:0] nxt;
    nxt = ab;
    if (dir == FWD) begin
      case (ab)
        2'b11:   nxt = 2'b01;
        2'b01:   nxt = 2'b00;
        2'b00:   nxt = 2'b10;
        default: nxt = 2'b11;
      endcase
    end else begin
      case (ab)
        2'b11:   nxt = 2'b10;
        2'b10:   nxt = 2'b00;
        2'b00:   nxt = 2'b01;
        default: nxt = 2'b11;
      endcase
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spinner_arbiter_quad_stepper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : quad_stepper
// Description : Combinational quadrature stepper. Given the present {A,B}
//               state, a step strobe and a direction, returns the {A,B}
//               state to load on the next clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_stepper
  import spinner_arb_pkg::*;
(
  input  logic [1:0] i_state,
  input  logic       i_step,
  input  enc_dir_t   i_dir,
  output logic [1:0] o_next_ab
);

  // Hold the state unless strobed; a strobe advances one Gray position.
  always_comb begin
    o_next_ab = i_state;
    if (i_step) begin
      o_next_ab = next_gray(i_state, i_dir);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spinner_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spinner_arbiter
// Description : Arbitrates four sources of signed spinner deltas. The first
//               source to transfer locks ownership until the bus has been
//               idle for IDLE_TO cycles. Accepted deltas accumulate into a
//               saturating position which is drained one quadrature step per
//               STEP_DIV-cycle tick onto enc_ab.
//               Optional build macro SPINNER_ARB_HW_ENC_EN adds a raw hw_enc
//               input that, once it moves, takes over enc_ab until the next
//               transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module spinner_arbiter
  import spinner_arb_pkg::*;
#(
  parameter int STEP_DIV = 3000,
  parameter int IDLE_TO  = 96000
) (
  input  logic                   clk_12m,
  input  logic                   reset,
  input  logic [SRC_N-1:0]       src_valid,
  input  logic [SRC_N*POS_W-1:0] src_delta,
  output logic [SRC_N-1:0]       src_ready,
`ifdef SPINNER_ARB_HW_ENC_EN
  input  logic [1:0]             hw_enc,
`endif
  output logic [1:0]             enc_ab,
  output logic [1:0]             owner,
  output logic                   owner_valid,
  output logic [POS_W-1:0]       pos,
  output logic                   busy
);

  localparam int c_IDX_W  = $clog2(SRC_N);
  localparam int c_DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int c_IDLE_W = (IDLE_TO > 1) ? $clog2(IDLE_TO) : 1;
  // Two guard bits cover pos + delta - adj over the full 12-bit input range.
  localparam int c_SUM_W  = POS_W + 2;

  localparam logic [c_DIV_W-1:0]         c_DIV_LAST  = c_DIV_W'(STEP_DIV - 1);
  localparam logic [c_IDLE_W-1:0]        c_IDLE_LAST = c_IDLE_W'(IDLE_TO - 1);
  localparam logic signed [c_SUM_W-1:0]  c_SUM_MAX   = c_SUM_W'(POS_MAX);
  localparam logic signed [c_SUM_W-1:0]  c_SUM_MIN   = c_SUM_W'(-POS_MAX);
  localparam logic [POS_W-1:0]           c_POS_HI    = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]           c_POS_LO    = POS_W'(-POS_MAX);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_DIV_W-1:0]        r_div;
  logic [c_IDLE_W-1:0]       r_idle;
  logic [c_IDX_W-1:0]        r_owner;
  logic                      r_owner_valid;
  logic signed [POS_W-1:0]   r_pos;
  logic [1:0]                r_soft_ab;

  logic [POS_W-1:0]          w_delta_arr [SRC_N];
  logic [SRC_N-1:0]          w_ready;
  logic [SRC_N-1:0]          w_xfer_vec;
  logic                      w_xfer;
  logic [c_IDX_W-1:0]        w_xfer_idx;
  logic [POS_W-1:0]          w_delta;
  logic                      w_tick;
  logic                      w_soft_step;
  enc_dir_t                  w_soft_dir;
  logic [1:0]                w_soft_next;
  logic signed [c_SUM_W-1:0] w_pos_ext;
  logic signed [c_SUM_W-1:0] w_delta_ext;
  logic signed [c_SUM_W-1:0] w_adj;
  logic signed [c_SUM_W-1:0] w_sum;
  logic [POS_W-1:0]          w_pos_next;

  // Split the flat delta bus into one lane per source.
  for (genvar gi = 0; gi < SRC_N; gi++) begin : g_unpack
    assign w_delta_arr[gi] = src_delta[gi*POS_W +: POS_W];
  end

  // --------------------------------------------------------------------------
  // Arbitration: locked owner is offered regardless of valid; otherwise the
  // lowest-index requester wins. Purely combinational so it also runs in reset.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ready = '0;
    if (r_owner_valid) begin
      w_ready[r_owner] = 1'b1;
    end else begin
      for (int i = SRC_N - 1; i >= 0; i--) begin
        if (src_valid[i]) begin
          w_ready    = '0;
          w_ready[i] = 1'b1;
        end
      end
    end
  end

  assign src_ready  = w_ready;
  assign w_xfer_vec = src_valid & w_ready;
  assign w_xfer     = |w_xfer_vec;

  // Index of the (at most one) transferring source.
  always_comb begin
    w_xfer_idx = '0;
    for (int i = 0; i < SRC_N; i++) begin
      if (w_xfer_vec[i]) begin
        w_xfer_idx = c_IDX_W'(i);
      end
    end
  end

  assign w_delta = w_delta_arr[w_xfer_idx];

  // --------------------------------------------------------------------------
  // Step tick and soft quadrature path
  // --------------------------------------------------------------------------
  assign w_tick      = (r_div == c_DIV_LAST);
  assign w_soft_step = w_tick && (r_pos != '0);
  assign w_soft_dir  = r_pos[POS_W-1] ? REV : FWD;

  quad_stepper u_soft_stepper (
    .i_state   (r_soft_ab),
    .i_step    (w_soft_step),
    .i_dir     (w_soft_dir),
    .o_next_ab (w_soft_next)
  );

  // Free-running step divider.
  always_ff @(posedge clk_12m) begin
    if (!reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_DIV_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator: accepted delta and the step just issued land together.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pos_ext   = {{(c_SUM_W-POS_W){r_pos[POS_W-1]}}, r_pos};
    w_delta_ext = '0;
    if (w_xfer) begin
      w_delta_ext = {{(c_SUM_W-POS_W){w_delta[POS_W-1]}}, w_delta};
    end
    w_adj = '0;
    if (w_soft_step) begin
      w_adj = r_pos[POS_W-1] ? '1 : c_SUM_W'(1);
    end
    w_sum = w_pos_ext + w_delta_ext - w_adj;
    // Symmetric clamp: -2048 is never produced so sign() drains evenly.
    if (w_sum > c_SUM_MAX) begin
      w_pos_next = c_POS_HI;
    end else if (w_sum < c_SUM_MIN) begin
      w_pos_next = c_POS_LO;
    end else begin
      w_pos_next = w_sum[POS_W-1:0];
    end
  end

  // Position accumulator and soft encoder state.
  always_ff @(posedge clk_12m) begin
    if (!reset) begin
      r_pos     <= '0;
      r_soft_ab <= 2'b11;
    end else begin
      r_pos     <= w_pos_next;
      r_soft_ab <= w_soft_next;
    end
  end

  // --------------------------------------------------------------------------
  // Ownership lock with idle release. The IDLE_TO-th consecutive idle cycle
  // drops the lock; the owner index is kept for observation.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_12m) begin
    if (!reset) begin
      r_owner       <= '0;
      r_owner_valid <= 1'b0;
      r_idle        <= '0;
    end else if (w_xfer) begin
      r_idle <= '0;
      if (!r_owner_valid) begin
        r_owner       <= w_xfer_idx;
        r_owner_valid <= 1'b1;
      end
    end else if (r_owner_valid) begin
      if (r_idle == c_IDLE_LAST) begin
        r_owner_valid <= 1'b0;
        r_idle        <= '0;
      end else begin
        r_idle <= r_idle + c_IDLE_W'(1);
      end
    end
  end

  assign owner       = r_owner;
  assign owner_valid = r_owner_valid;
  assign pos         = r_pos;
  assign busy        = (r_pos != '0);

`ifdef SPINNER_ARB_HW_ENC_EN
  // --------------------------------------------------------------------------
  // Hardware encoder pass-through: synchronised raw encoder drives its own
  // quadrature state, which owns enc_ab from its first movement until the
  // next transfer hands control back to the soft path.
  // --------------------------------------------------------------------------
  logic [1:0] r_hw_sync1;
  logic [1:0] r_hw_sync2;
  logic [1:0] r_hw_prev;
  logic [1:0] r_hw_ab;
  logic       r_hw_mode;
  logic       w_hw_step;
  logic       w_hw_change;
  enc_dir_t   w_hw_dir;
  logic [1:0] w_hw_next;

  assign w_hw_step   = r_hw_sync2[1] ^ r_hw_prev[1];
  assign w_hw_change = (r_hw_sync2 != r_hw_prev);
  assign w_hw_dir    = (r_hw_sync2[1] ^ r_hw_sync2[0]) ? FWD : REV;

  quad_stepper u_hw_stepper (
    .i_state   (r_hw_ab),
    .i_step    (w_hw_step),
    .i_dir     (w_hw_dir),
    .o_next_ab (w_hw_next)
  );

  // Synchroniser, edge history, hw quadrature state and mode select.
  always_ff @(posedge clk_12m) begin
    if (!reset) begin
      r_hw_sync1 <= 2'b11;
      r_hw_sync2 <= 2'b11;
      r_hw_prev  <= 2'b11;
      r_hw_ab    <= 2'b11;
      r_hw_mode  <= 1'b0;
    end else begin
      r_hw_sync1 <= hw_enc;
      r_hw_sync2 <= r_hw_sync1;
      r_hw_prev  <= r_hw_sync2;
      r_hw_ab    <= w_hw_next;
      if (w_xfer) begin
        r_hw_mode <= 1'b0;
      end else if (w_hw_change) begin
        r_hw_mode <= 1'b1;
      end
    end
  end

  assign enc_ab = r_hw_mode ? r_hw_ab : r_soft_ab;
`else
  assign enc_ab = r_soft_ab;
`endif

endmodule
`default_nettype wire

// File: doc/spinner_arbiter.md
SPINNER_ARBITER -- requirements
Module: spinner_arbiter

Interface
REQ-001 SHALL have parameter STEP_DIV, default 3000: clk_12m cycles per encoder step tick (4 kHz).
REQ-002 SHALL have parameter IDLE_TO, default 96000: idle clk_12m cycles before the owner lock is released (8 ms).
REQ-003 SHALL have port clk_12m, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port src_valid, input, 4: source i presents a delta.
REQ-006 SHALL have port src_delta, input, 48: four 12-bit two's-complement deltas; source i uses bits [12i+11:12i].
REQ-007 SHALL have port src_ready, output, 4: source i is accepted this cycle.
REQ-008 SHALL have port enc_ab, output, 2: quadrature {A,B} to the game spinner input.
REQ-009 SHALL have port owner, output, 2: index of the locked source.
REQ-010 SHALL have port owner_valid, output, 1: lock held.
REQ-011 SHALL have port pos, output, 12: signed pending-step accumulator.
REQ-012 SHALL have port busy, output, 1: pos != 0.

Function
REQ-013 SHALL transfer on src_valid[i] & src_ready[i]; src_ready is combinational.
REQ-014 SHALL drive src_ready when owner_valid=1 as one-hot on owner, regardless of src_valid.
REQ-015 SHALL drive src_ready when owner_valid=0 as one-hot on the lowest-index asserted src_valid, else 0.
REQ-016 SHALL, on a transfer while unlocked, set owner=i and owner_valid=1 the next cycle.
REQ-017 SHALL clear an idle counter on every transfer and increment it otherwise while locked.
REQ-018 SHALL clear owner_valid on the cycle the idle counter reaches IDLE_TO-1; owner keeps its last value.
REQ-019 SHALL update pos one cycle after a transfer: pos <= sat(pos + delta - step_adj).
REQ-020 SHALL define sat as a clamp to [-2047,+2047]; -2048 is never produced.
REQ-021 SHALL assert a step tick every STEP_DIV cycles from a free-running divider.
REQ-022 SHALL, on a tick with pos != 0, advance enc_ab one Gray state and set step_adj = sign(pos); otherwise step_adj = 0.
REQ-023 SHALL, when a tick and a transfer coincide, apply both delta and step_adj in the same update.
REQ-024 SHALL step for pos>0 as 11->01->00->10->11.
REQ-025 SHALL step for pos<0 as 11->10->00->01->11.
REQ-026 SHALL accept a zero delta as activity; pos is unchanged.
REQ-027 SHALL keep enc_ab constant when pos=0, and continue draining after lock release.

Reset
REQ-028 SHALL, while reset=0 at a clock edge, set pos=0, enc_ab=2'b11, owner=0, owner_valid=0, and clear the divider and idle counter.
REQ-029 SHALL discard any delta in flight when reset is asserted mid-operation.
REQ-030 SHALL make src_ready follow REQ-015 during reset (combinational), with no transfer taking effect.

Configuration
REQ-031 SHALL, with SPINNER_ARB_HW_ENC_EN defined, add input hw_enc[1:0]: a raw 600-ppr encoder, 2-flop synchronised.
REQ-032 SHALL, with the macro defined, produce one hw Gray step per edge of synchronised A, direction A^B: 1 -> REQ-024 order, 0 -> REQ-025 order.
REQ-033 SHALL, with the macro defined, set hw_mode on any synchronised hw_enc change.
REQ-034 SHALL, with the macro defined, clear hw_mode on any transfer.
REQ-035 SHALL, with the macro defined, drive enc_ab from the hw state when hw_mode=1; hw state resets to 2'b11.
REQ-036 SHALL, without SPINNER_ARB_HW_ENC_EN, have no hw_enc port and drive enc_ab always from REQ-022.

Structure
REQ-037 SHALL place SRC_N=4, POS_W=12, POS_MAX=2047, the enc_dir_t enum (FWD, REV), and the next-Gray-state function in package spinner_arb_pkg.
REQ-038 SHALL use sub-module quad_stepper (state, step strobe, direction -> next {A,B}), instantiated once for the soft path and once for the hw path.

Verification
REQ-039 SHALL check, with STEP_DIV=4: src0 delta +3 from reset -> enc_ab 01,00,10 on three consecutive ticks, then pos=0 and busy=0.
REQ-040 SHALL check, with src0 and src2 valid in the same cycle while unlocked, src_ready=0001 and owner=0; src2 stays stalled until IDLE_TO idle cycles have elapsed, then src_ready=0100.
REQ-041 SHALL check that pos=+2000 followed by delta +100 gives pos=+2047; pos=-2000 followed by delta -100 gives pos=-2047.
REQ-042 SHALL check that pos=+1, with a delta of -1 landing on a tick, gives pos=-1 and one forward step.
REQ-043 SHALL check that reset=0 asserted with pos=+50 mid-stream gives pos=0, enc_ab=11, owner_valid=0 the next cycle.
REQ-044 SHALL check, with SPINNER_ARB_HW_ENC_EN defined: 4 A-edges with A^B=1 -> enc_ab follows the hw sequence; a subsequent src1 transfer -> enc_ab returns to the soft path.
